corg_alu_seq: RTL and testbench

- Parametrised, multi-cycle successor to the 16-bit combinational CORG ALU.
- Accepts one operation at a time over a valid/ready input handshake and returns a registered result plus status flags over a valid/ready output handshake.
- Single-cycle logic/arithmetic ops; iterative full-range shifter; optional iterative shift-add multiplier.
- Sits between the CORG decode/issue stage and register-file writeback.

---
 rtl/corg_alu_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_corg_alu_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/corg_alu_seq.sv
// corg_alu_seq: multi-cycle CORG ALU with valid/ready handshakes on both sides.
// Logic/arithmetic/compare ops finish on the accept edge. Shifts move one bit
// per cycle. MUL is an iterative shift-add over WIDTH cycles.
module corg_alu_seq #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [WIDTH-1:0]  work_q, work_d;   // shift operand, or multiplicand for MUL
  logic [WIDTH-1:0]  lo_q, lo_d;       // MUL: multiplier / low product half
  logic [WIDTH-1:0]  hi_q, hi_d;       // MUL: high product half
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic              ill_q, ill_d, out_valid_q, out_valid_d;

  logic [SHW-1:0]    sh;
  logic [WIDTH:0]    add_w, sub_w, mul_sum;
  logic [WIDTH-1:0]  alu_res, step_val, hi_next;
  logic              alu_c, alu_v, alu_ill, is_multi, step_c;

  assign sh = b[SHW-1:0];

  // Single-cycle ops evaluated straight from the input operands at accept.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_ill  = 1'b0;
    is_multi = 1'b0;
    add_w    = {1'b0, a} + {1'b0, b};
    sub_w    = {1'b0, b} - {1'b0, a};
    case (op)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != b[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLL, OP_SRL, OP_SRA: begin
        alu_res  = a;                  // sh=0 passes a through, carry stays 0
        is_multi = (sh != '0);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_MUL: begin
        is_multi = MUL_EN;
        alu_ill  = !MUL_EN;
      end
      default: alu_ill = 1'b1;
    endcase
  end

  // One iteration of the shifter or multiplier on the captured operands.
  always_comb begin
    step_val = work_q;
    step_c   = 1'b0;
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, work_q} : '0);
    hi_next  = mul_sum[WIDTH:1];
    case (op_q)
      OP_SLL: begin
        step_val = {work_q[WIDTH-2:0], 1'b0};
        step_c   = work_q[WIDTH-1];
      end
      OP_SRL: begin
        step_val = {1'b0, work_q[WIDTH-1:1]};
        step_c   = work_q[0];
      end
      OP_SRA: begin
        step_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        step_c   = work_q[0];
      end
      default: begin                   // MUL: right-shifting product register
        step_val = {mul_sum[0], lo_q[WIDTH-1:1]};
        step_c   = |hi_next;
      end
    endcase
  end

  // Next-state and datapath control for IDLE/BUSY/DONE.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    c_d      = c_q;
    v_d      = v_q;
    ill_d    = ill_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d   = op;
          work_d = a;
          lo_d   = b;
          hi_d   = '0;
          ill_d  = alu_ill;
          if (is_multi) begin
            state_d = S_BUSY;
            cnt_d   = (op == OP_MUL) ? CW'(WIDTH) : {1'b0, sh};
          end else begin
            state_d  = S_DONE;
            result_d = alu_res;
            c_d      = alu_c;
            v_d      = alu_v;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (op_q == OP_MUL) begin
          hi_d = hi_next;
          lo_d = step_val;
        end else begin
          work_d = step_val;
        end
        if (cnt_q == CW'(1)) begin
          state_d  = S_DONE;
          result_d = step_val;
          c_d      = step_c;
          v_d      = 1'b0;
        end
      end
      default: begin                   // S_DONE: hold until consumer takes it
        if (out_ready) state_d = S_IDLE;
      end
    endcase
    z_d         = (result_d == '0);
    n_d         = result_d[WIDTH-1];
    out_valid_d = (state_d == S_DONE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      work_q      <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      ill_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      op_q        <= op_d;
      work_q      <= work_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      z_q         <= z_d;
      n_q         <= n_d;
      c_q         <= c_d;
      v_q         <= v_d;
      ill_q       <= ill_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_corg_alu_seq.sv
// Self-checking bench for corg_alu_seq (WIDTH=16): vector table plus
// hand-written sequences for backpressure, reset abort and MUL_EN=0.
module tb_corg_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]  op = '0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, flag_z, flag_n, flag_c, flag_v, illegal;
  logic [15:0] result;

  logic        nm_in_valid = 1'b0, nm_out_ready = 1'b0;
  logic        nm_in_ready, nm_out_valid, nm_z, nm_n, nm_c, nm_v, nm_ill;
  logic [15:0] nm_result;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  corg_alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .flag_v(flag_v), .illegal(illegal)
  );

  corg_alu_seq #(.WIDTH(16), .MUL_EN(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
    .op(op), .a(a), .b(b), .out_valid(nm_out_valid), .out_ready(nm_out_ready),
    .result(nm_result), .flag_z(nm_z), .flag_n(nm_n), .flag_c(nm_c),
    .flag_v(nm_v), .illegal(nm_ill)
  );

  // flags packed as {illegal, z, n, c, v}; lat = edges after the accept edge
  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [4:0]  flags;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Wait for in_ready, present the op, and return just after the accept edge.
  task automatic start_op(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
  endtask

  // Count edges after accept until out_valid; returns -1 on timeout. Ends at a negedge.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin lat = i; break; end
      @(posedge clk);
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    start_op(v.op, v.a, v.b);
    wait_valid(lat);
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
    check($sformatf("v%0d_result", idx), {16'd0, result}, {16'd0, v.res});
    check($sformatf("v%0d_flags", idx), {27'd0, illegal, flag_z, flag_n, flag_c, flag_v},
          {27'd0, v.flags});
    handoff();
  endtask

  initial begin
    int     lat;
    bit     ok;
    //        op     a         b         res       {i,z,n,c,v}  lat
    vecs[0]  = '{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 5'b00101, 0};
    vecs[1]  = '{4'd2,  16'h0005, 16'h0003, 16'hFFFE, 5'b00110, 0};
    vecs[2]  = '{4'd2,  16'h8000, 16'h0001, 16'h8001, 5'b00111, 0};
    vecs[3]  = '{4'd7,  16'h8001, 16'h000F, 16'hFFFF, 5'b00100, 15};
    vecs[4]  = '{4'd6,  16'h8001, 16'h0001, 16'h4000, 5'b00010, 1};
    vecs[5]  = '{4'd5,  16'h1234, 16'h0010, 16'h1234, 5'b00000, 0};
    vecs[6]  = '{4'd10, 16'h0100, 16'h0101, 16'h0100, 5'b00010, 16};
    vecs[7]  = '{4'd10, 16'h0003, 16'h0005, 16'h000F, 5'b00000, 16};
    vecs[8]  = '{4'd1,  16'hF0F0, 16'h0FF0, 16'h00F0, 5'b00000, 0};
    vecs[9]  = '{4'd8,  16'hFFFF, 16'h0001, 16'h0001, 5'b00000, 0};
    vecs[10] = '{4'd9,  16'hFFFF, 16'h0001, 16'h0000, 5'b01000, 0};
    vecs[11] = '{4'd12, 16'h1234, 16'h5678, 16'h0000, 5'b11000, 0};
    vecs[12] = '{4'd3,  16'h00FF, 16'hFF00, 16'hFFFF, 5'b00100, 0};
    vecs[13] = '{4'd4,  16'hAAAA, 16'hAAAA, 16'h0000, 5'b01000, 0};
    vecs[14] = '{4'd5,  16'h2001, 16'h0013, 16'h0008, 5'b00010, 3};
    vecs[15] = '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 5'b01010, 0};
    vecs[16] = '{4'd7,  16'h7000, 16'h000D, 16'h0003, 5'b00010, 13};

    // Reset held, then released
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", {16'd0, result}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_flags", {27'd0, illegal, flag_z, flag_n, flag_c, flag_v}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // MUL on the MUL_EN=0 build is illegal
    @(negedge clk);
    nm_in_valid = 1'b1; op = 4'd10; a = 16'h0003; b = 16'h0005;
    @(posedge clk); #1;
    nm_in_valid = 1'b0;
    @(negedge clk);
    check("nomul_out_valid", {31'd0, nm_out_valid}, 32'd1);
    check("nomul_result", {16'd0, nm_result}, 32'd0);
    check("nomul_flags", {27'd0, nm_ill, nm_z, nm_n, nm_c, nm_v}, 32'b11000);
    nm_out_ready = 1'b1;
    @(posedge clk); #1;
    nm_out_ready = 1'b0;

    // Backpressure: hold DONE for 10 cycles while a new request waits
    start_op(4'd0, 16'h0001, 16'h0002);
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd0);
    in_valid = 1'b1; op = 4'd4; a = 16'hFF00; b = 16'h0F0F;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_valid || in_ready || result !== 16'h0003 || flag_z || flag_n) ok = 1'b0;
    end
    check("bp_hold_stable", {31'd0, ok}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_after_handoff_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_after_handoff_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_second_op_valid", {31'd0, out_valid}, 32'd1);
    check("bp_second_op_result", {16'd0, result}, 32'h0000F00F);
    handoff();

    // Reset 3 cycles into a 12-bit shift
    start_op(4'd5, 16'h0001, 16'h000C);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_result", {16'd0, result}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b0;
    end
    check("abort_no_valid", {31'd0, ok}, 32'd1);
    run_vec(100, vecs[8]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
